// File: rtl/risc_pkg.sv
// Shared encodings, IR field positions and enums for the RISC execution core.
package risc_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;
  localparam int RN_MSB  = 10;
  localparam int RN_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 5;
  localparam int SH_MSB  = 4;
  localparam int SH_LSB  = 3;
  localparam int RM_MSB  = 2;
  localparam int RM_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_DECODE,
    ST_GET_A,
    ST_GET_B,
    ST_EXEC,
    ST_WRITE,
    ST_WRITE_IMM
  } state_e;

endpackage

// File: rtl/risc_exec_core_if.sv
// Instruction/status bundle of the execution core, used by benches and wrappers.
interface risc_exec_core_if #(
  parameter int WIDTH = 16
) ();
  logic             s;
  logic             load;
  logic [15:0]      in;
  logic [WIDTH-1:0] out;
  logic             N;
  logic             V;
  logic             Z;
  logic             Cy;
  logic             w;
  logic             ill;

  modport master (output s, load, in, input out, N, V, Z, Cy, w, ill);
  modport slave  (input s, load, in, output out, N, V, Z, Cy, w, ill);
endinterface

// File: rtl/regfile_p.sv
// NREG x WIDTH register file: one synchronous write port, one combinational read port.
module regfile_p #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [2:0]       waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [2:0]       raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (32'(waddr_i) < NREG)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < NREG) rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/risc_exec_core.sv
// Multi-cycle RISC execution core: WAIT/DECODE/GET_A/GET_B/EXEC/WRITE/WRITE_IMM sequencer.
module risc_exec_core
  import risc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic             load,
  input  logic [15:0]      in,
  output logic [WIDTH-1:0] out,
  output logic             N,
  output logic             V,
  output logic             Z,
  output logic             Cy,
  output logic             w,
  output logic             ill
);

  state_e           state_q, state_d;
  logic [15:0]      ir_q;
  logic [15:0]      xr_q;
  logic [WIDTH-1:0] a_q, b_q, out_q;
  logic             n_q, v_q, z_q, c_q, ill_q;

  logic [2:0]       opc, rn, rd, rm;
  logic [1:0]       op, sh;
  logic             legal, is_imm, is_cmp;
  logic [WIDTH-1:0] shb, res, imm_x, rf_rdata, rf_wdata;
  logic [2:0]       rf_raddr, rf_waddr;
  logic             rf_we;

  function automatic logic idx_ok(input logic [2:0] r);
    return 32'(r) < NREG;
  endfunction

  // Decode works on xr_q, a copy taken at start, so a load on the start edge cannot disturb it.
  assign opc   = xr_q[OPC_MSB:OPC_LSB];
  assign op    = xr_q[OP_MSB:OP_LSB];
  assign rn    = xr_q[RN_MSB:RN_LSB];
  assign rd    = xr_q[RD_MSB:RD_LSB];
  assign sh    = xr_q[SH_MSB:SH_LSB];
  assign rm    = xr_q[RM_MSB:RM_LSB];
  assign imm_x = WIDTH'($signed(xr_q[IMM_MSB:IMM_LSB]));

  always_comb begin
    legal  = 1'b0;
    is_imm = 1'b0;
    is_cmp = 1'b0;
    if (opc == OPC_MOV && op == OP_MOVI) begin
      legal  = idx_ok(rn);
      is_imm = 1'b1;
    end else if (opc == OPC_MOV && op == OP_MOVR) begin
      legal = idx_ok(rd) && idx_ok(rm);
    end else if (opc == OPC_ALU) begin
      case (op)
        OP_ADD, OP_AND: legal = idx_ok(rn) && idx_ok(rd) && idx_ok(rm);
        OP_MVN:         legal = idx_ok(rd) && idx_ok(rm);
        default: begin
          legal  = idx_ok(rn) && idx_ok(rm);
          is_cmp = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    shb = b_q;
    case (shift_e'(sh))
      SH_LSL:  shb = {b_q[WIDTH-2:0], 1'b0};
      SH_LSR:  shb = {1'b0, b_q[WIDTH-1:1]};
      SH_ASR:  shb = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: shb = b_q;
    endcase
  end

  always_comb begin
    res = shb;
    if (opc == OPC_ALU) begin
      case (op)
        OP_ADD:  res = a_q + shb;
        OP_CMP:  res = a_q - shb;
        OP_AND:  res = a_q & shb;
        default: res = ~shb;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_WAIT;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:      if (s) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!legal)      state_d = ST_WAIT;
        else if (is_imm) state_d = ST_WRITE_IMM;
        else             state_d = ST_GET_A;
      end
      ST_GET_A:     state_d = ST_GET_B;
      ST_GET_B:     state_d = ST_EXEC;
      ST_EXEC:      state_d = is_cmp ? ST_WAIT : ST_WRITE;
      ST_WRITE:     state_d = ST_WAIT;
      ST_WRITE_IMM: state_d = ST_WAIT;
      default:      state_d = ST_WAIT;
    endcase
  end

  // Output / control logic
  always_comb begin
    w        = (state_q == ST_WAIT);
    rf_raddr = (state_q == ST_GET_B) ? rm : rn;
    rf_we    = (state_q == ST_WRITE) || (state_q == ST_WRITE_IMM);
    rf_waddr = (state_q == ST_WRITE_IMM) ? rn : rd;
    rf_wdata = (state_q == ST_WRITE_IMM) ? imm_x : out_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ir_q  <= '0;
      xr_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      n_q   <= 1'b0;
      v_q   <= 1'b0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      if (state_q == ST_WAIT) begin
        if (load) ir_q <= in;
        if (s) begin
          xr_q  <= ir_q;
          ill_q <= 1'b0;
        end
      end
      if (state_q == ST_DECODE && !legal) ill_q <= 1'b1;
      if (state_q == ST_GET_A) a_q <= rf_rdata;
      if (state_q == ST_GET_B) b_q <= rf_rdata;
      if (state_q == ST_EXEC) begin
        out_q <= res;
        if (is_cmp) begin
          n_q <= res[WIDTH-1];
          z_q <= (res == '0);
          c_q <= (a_q >= shb);
          v_q <= (a_q[WIDTH-1] ^ shb[WIDTH-1]) & (res[WIDTH-1] ^ a_q[WIDTH-1]);
        end
      end
    end
  end

  regfile_p #(.WIDTH(WIDTH), .NREG(NREG)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (rf_we),
    .waddr_i (rf_waddr),
    .wdata_i (rf_wdata),
    .raddr_i (rf_raddr),
    .rdata_o (rf_rdata)
  );

  assign out = out_q;
  assign N   = n_q;
  assign V   = v_q;
  assign Z   = z_q;
  assign Cy  = c_q;
  assign ill = ill_q;

endmodule

// File: doc/risc_exec_core.md
RISC_EXEC_CORE -- requirements
Module: risc_exec_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the datapath and register width in bits; legal range 8..32.
REQ-002 SHALL have parameter NREG, default 8, giving the register count; legal range 2..8; register fields are 3 bits and indices >= NREG are illegal.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port s  input  1  start request, sampled in WAIT only.
REQ-006 SHALL have port load  input  1  capture `in` into the instruction register (IR).
REQ-007 SHALL have port in  input  16  instruction word.
REQ-008 SHALL have port out  output  WIDTH  result register C.
REQ-009 SHALL have ports N, V, Z, Cy  output  1 each  negative, overflow, zero and carry (no-borrow) status flags.
REQ-010 SHALL have port w  output  1  high while the FSM is in WAIT.
REQ-011 SHALL have port ill  output  1  high when the last started instruction was illegal.

Function
REQ-012 SHALL decode IR fields as opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
REQ-013 SHALL implement opcode 110 op 10 (MOV imm): Rn <- sign-extend(imm8) to WIDTH; out and flags unchanged.
REQ-014 SHALL implement opcode 110 op 00 (MOV reg): Rd <- shift(Rm); out <- same value.
REQ-015 SHALL implement opcode 101: op 00 ADD Rd <- Rn + shift(Rm); op 10 AND Rd <- Rn & shift(Rm); op 11 MVN Rd <- ~shift(Rm); out <- result in each case.
REQ-016 SHALL implement opcode 101 op 01 (CMP): compute Rn - shift(Rm) into out; update N, V, Z and Cy; write no register.
REQ-017 SHALL apply shifter modes per sh: 00 = none, 01 = LSL by 1 (zero fill), 10 = LSR by 1 (zero fill), 11 = ASR by 1 (MSB copied).
REQ-018 SHALL truncate all arithmetic modulo 2^WIDTH; N = result MSB; Z = (result == 0); V = signed overflow of the subtraction; Cy = 1 when Rn >= shift(Rm) unsigned.
REQ-019 SHALL leave flags unchanged for every instruction other than CMP.
REQ-020 SHALL use FSM states WAIT, DECODE, GET_A, GET_B, EXEC, WRITE, WRITE_IMM.
REQ-021 SHALL transition WAIT->DECODE when s=1; DECODE->WRITE_IMM for MOV imm; DECODE->WAIT for an illegal instruction; otherwise DECODE->GET_A->GET_B->EXEC; EXEC->WAIT for CMP, else EXEC->WRITE->WAIT; WRITE_IMM->WAIT.
REQ-022 SHALL give cycle counts from the s-sampling edge to w=1 of: MOV imm 2, CMP 4, other legal instructions 5, illegal 1.
REQ-023 SHALL load IR only while in WAIT; load=1 in any other state SHALL be ignored.
REQ-024 SHALL give s=1 at the edge that returns to WAIT no effect; s held high in WAIT SHALL re-execute IR.
REQ-025 SHALL, when load=1 and s=1 are sampled on the same WAIT edge, execute the old IR and load the new IR.
REQ-026 SHALL treat any undefined opcode/op pair, or any used register index >= NREG, as illegal; illegal instructions change no register, out or flags.
REQ-027 SHALL set ill in DECODE on an illegal instruction and clear it on the next accepted start.
REQ-028 SHALL read GET_B operand Rm as the value written by the immediately preceding instruction (no stale read).

Reset
REQ-029 SHALL, when reset=0 at any clock edge in any state, abort the current instruction and enter WAIT.
REQ-030 SHALL clear all registers, IR, out, N, V, Z, Cy and ill to 0 on reset; w SHALL read 1 in the cycle after reset.

Structure
REQ-031 SHALL place the opcode/op encodings, shift-mode enum, state enum and IR field positions in shared package risc_pkg.
REQ-032 SHALL implement the register file (NREG x WIDTH, one synchronous write port, one combinational read port) as sub-module regfile_p, instantiated once.

Verification
REQ-033 SHALL verify: MOV R7,#10; MOV R0,#-4; ADD R1,R7,R0 -> R1=6, out=6; MOV imm returns w=1 after 2 cycles and ADD after 5.
REQ-034 SHALL verify: R4=5, R3=11; CMP R4,R3 -> out=0xFFFA, N=1, V=0, Z=0, Cy=0; CMP R4,R4 -> out=0, Z=1, Cy=1; R3 and R4 unchanged.
REQ-035 SHALL verify: R0=0xFFFC; MOV R2,R0 ASR -> 0xFFFE; MOV R2,R0 LSR -> 0x7FFE; MVN R5,R0 LSL -> 0x0007.
REQ-036 SHALL verify: R5=0xFE03, R4=16256; CMP R5,R4 LSL#1 -> out=0x7F03, N=0, V=1, Z=0, Cy=1.
REQ-037 SHALL verify: IR=0x0000 started -> ill=1 and w=1 one cycle later with no state changed; load pulsed during EXEC leaves IR unchanged.
REQ-038 SHALL verify: reset=0 asserted in EXEC -> WAIT with all registers 0; a WIDTH=8 instance executing MOV R1,#-4 -> R1=0xFC.
